// File: rtl/abr_1r1w_be_zram.sv
// One-read/one-write RAM with per-lane write strobes, write-first forwarding, 1- or 2-cycle read pipeline
// and a zeroize sequencer. Define ABR_RAM_PARITY_EN to add per-lane even-parity storage and checking.
module abr_1r1w_be_zram #(
    parameter int  DEPTH        = 64,
    parameter int  DATA_WIDTH   = 32,
    parameter int  STROBE_WIDTH = 8,
    parameter int  READ_LATENCY = 1,
    localparam int NUM_LANES    = DATA_WIDTH / STROBE_WIDTH,
    localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  zeroize_i,
    output logic                  busy_o,
    input  logic                  we_i,
    input  logic [NUM_LANES-1:0]  wstrobe_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
`ifdef ABR_RAM_PARITY_EN
    ,
    input  logic [NUM_LANES-1:0]  perr_inject_i,
    output logic [NUM_LANES-1:0]  perr_o
`endif
);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("abr_1r1w_be_zram: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % STROBE_WIDTH != 0) begin : g_bad_width
        $error("abr_1r1w_be_zram: DATA_WIDTH must be a multiple of STROBE_WIDTH");
    end

    typedef enum logic {IDLE, ZERO} state_t;

    localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_row,
        input logic [DATA_WIDTH-1:0] new_row,
        input logic [NUM_LANES-1:0]  strobe
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_row;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (strobe[l]) res[l*STROBE_WIDTH +: STROBE_WIDTH] = new_row[l*STROBE_WIDTH +: STROBE_WIDTH];
        end
        return res;
    endfunction

`ifdef ABR_RAM_PARITY_EN
    function automatic logic [NUM_LANES-1:0] lane_parity(input logic [DATA_WIDTH-1:0] row);
        logic [NUM_LANES-1:0] p;
        for (int l = 0; l < NUM_LANES; l++) begin
            p[l] = ^row[l*STROBE_WIDTH +: STROBE_WIDTH];
        end
        return p;
    endfunction
`endif

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  idle, zero_start, waddr_ok, raddr_ok;
    logic                  wr_en, rd_issue, collide;
    logic [DATA_WIDTH-1:0] row_p0, rd_word_p0;
    logic                  src_vld;
    logic [DATA_WIDTH-1:0] src_data;

    assign idle       = (state == IDLE);
    assign zero_start = idle && zeroize_i;
    assign waddr_ok   = ({1'b0, waddr_i} < DEPTH_X);
    assign raddr_ok   = ({1'b0, raddr_i} < DEPTH_X);
    assign wr_en      = idle && we_i && waddr_ok;
    // A read presented together with the zeroize request is dropped so nothing completes during ZERO.
    assign rd_issue   = idle && re_i && !zeroize_i;
    assign collide    = rd_issue && wr_en && (raddr_i == waddr_i);

    // ---- stage p0: array read and write-first merge ----
    assign row_p0 = mem[raddr_i];

    always_comb begin
        rd_word_p0 = '0;
        if (raddr_ok) rd_word_p0 = collide ? merge_lanes(row_p0, wdata_i, wstrobe_i) : row_p0;
    end

`ifdef ABR_RAM_PARITY_EN
    logic [NUM_LANES-1:0] par_mem [DEPTH];
    logic [NUM_LANES-1:0] wr_par, rd_par_p0, rd_perr_p0, src_perr;

    assign wr_par     = lane_parity(wdata_i) ^ perr_inject_i;
    assign rd_par_p0  = collide ? ((par_mem[raddr_i] & ~wstrobe_i) | (wr_par & wstrobe_i))
                                : par_mem[raddr_i];
    assign rd_perr_p0 = raddr_ok ? (rd_par_p0 ^ lane_parity(rd_word_p0)) : '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (zeroize_i) begin
                        state  <= ZERO;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                ZERO: begin
                    if (cnt == LAST_ROW) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset only blocks the write; it never clears the array, so an aborted zeroize leaves rows intact.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (!idle) begin
                mem[cnt] <= '0;
`ifdef ABR_RAM_PARITY_EN
                par_mem[cnt] <= '0;
`endif
            end else if (wr_en) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (wstrobe_i[l]) begin
                        mem[waddr_i][l*STROBE_WIDTH +: STROBE_WIDTH] <= wdata_i[l*STROBE_WIDTH +: STROBE_WIDTH];
`ifdef ABR_RAM_PARITY_EN
                        par_mem[waddr_i][l] <= wr_par[l];
`endif
                    end
                end
            end
        end
    end

    // ---- stage p1: optional output register for READ_LATENCY=2 ----
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] rd_data_p1;
        logic                  vld_p1;
`ifdef ABR_RAM_PARITY_EN
        logic [NUM_LANES-1:0]  perr_p1;
`endif

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vld_p1     <= 1'b0;
                rd_data_p1 <= '0;
`ifdef ABR_RAM_PARITY_EN
                perr_p1    <= '0;
`endif
            end else begin
                vld_p1 <= rd_issue;
                if (rd_issue) begin
                    rd_data_p1 <= rd_word_p0;
`ifdef ABR_RAM_PARITY_EN
                    perr_p1    <= rd_perr_p0;
`endif
                end
            end
        end

        assign src_vld  = vld_p1;
        assign src_data = rd_data_p1;
`ifdef ABR_RAM_PARITY_EN
        assign src_perr = perr_p1;
`endif
    end else begin : g_lat1
        assign src_vld  = rd_issue;
        assign src_data = rd_word_p0;
`ifdef ABR_RAM_PARITY_EN
        assign src_perr = rd_perr_p0;
`endif
    end

    // ---- output stage: rdata_o holds between reads, cleared on entry to ZERO ----
    always_ff @(posedge clk_i) begin
        if (rst_i || zero_start) begin
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= src_vld;
            if (src_vld) rdata_o <= src_data;
        end
    end

`ifdef ABR_RAM_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || zero_start) begin
            perr_o <= '0;
        end else begin
            perr_o <= src_vld ? src_perr : '0;
        end
    end
`endif

endmodule

// File: tb/tb_abr_1r1w_be_zram.sv
// Self-checking bench for abr_1r1w_be_zram: a 64-row/latency-1 instance and a 48-row/latency-2 instance
// checked against array models; parity checks compile in when ABR_RAM_PARITY_EN is defined.
module tb_abr_1r1w_be_zram;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_zero, a_busy, a_we, a_re, a_rvalid;
    logic [3:0]  a_strb, a_inj;
    logic [5:0]  a_waddr, a_raddr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_zero, b_busy, b_we, b_re, b_rvalid;
    logic [3:0]  b_strb, b_inj;
    logic [5:0]  b_waddr, b_raddr;
    logic [31:0] b_wdata, b_rdata;
`ifdef ABR_RAM_PARITY_EN
    logic [3:0]  a_perr, b_perr;
`endif

    abr_1r1w_be_zram #(.DEPTH(64), .DATA_WIDTH(32), .STROBE_WIDTH(8), .READ_LATENCY(1)) u_a (
        .clk_i(clk), .rst_i(rst), .zeroize_i(a_zero), .busy_o(a_busy),
        .we_i(a_we), .wstrobe_i(a_strb), .waddr_i(a_waddr), .wdata_i(a_wdata),
        .re_i(a_re), .raddr_i(a_raddr), .rdata_o(a_rdata), .rvalid_o(a_rvalid)
`ifdef ABR_RAM_PARITY_EN
        , .perr_inject_i(a_inj), .perr_o(a_perr)
`endif
    );

    abr_1r1w_be_zram #(.DEPTH(48), .DATA_WIDTH(32), .STROBE_WIDTH(8), .READ_LATENCY(2)) u_b (
        .clk_i(clk), .rst_i(rst), .zeroize_i(b_zero), .busy_o(b_busy),
        .we_i(b_we), .wstrobe_i(b_strb), .waddr_i(b_waddr), .wdata_i(b_wdata),
        .re_i(b_re), .raddr_i(b_raddr), .rdata_o(b_rdata), .rvalid_o(b_rvalid)
`ifdef ABR_RAM_PARITY_EN
        , .perr_inject_i(b_inj), .perr_o(b_perr)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference state: row contents and, per lane, whether the stored parity is deliberately wrong.
    logic [31:0] ma [64];
    logic [3:0]  ca [64];
    logic [31:0] mb [48];
    logic [3:0]  cb [48];

    typedef struct {
        logic        we;
        logic [3:0]  strb;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic        re;
        logic [5:0]  raddr;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        a_zero = 0; a_we = 0; a_re = 0; a_strb = 0; a_waddr = 0; a_raddr = 0; a_wdata = 0; a_inj = 0;
        b_zero = 0; b_we = 0; b_re = 0; b_strb = 0; b_waddr = 0; b_raddr = 0; b_wdata = 0; b_inj = 0;
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int l = 0; l < 4; l++) if (strb[l]) r[8*l +: 8] = new_v[8*l +: 8];
        return r;
    endfunction

    task automatic fill_a();
        for (int r = 0; r < 64; r++) begin
            a_we = 1; a_strb = 4'hF; a_waddr = 6'(r); a_wdata = $urandom | 32'h1;
            ma[r] = a_wdata; ca[r] = 4'h0;
            tick();
        end
        idle_in();
    endtask

    task automatic zero_models_a();
        for (int r = 0; r < 64; r++) begin ma[r] = 0; ca[r] = 0; end
    endtask

    initial begin
        int na, nb, guard;
        logic        ea_v, eb_v, pb_v;
        logic [31:0] ea_d, eb_d, pb_d, last_a, last_b;
        logic [3:0]  ea_p, eb_p, pb_p;

        idle_in();
        rst = 1;
        tick(); tick();
        chk("rst_a_busy", a_busy, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_b_rdata", b_rdata, 0);
        rst = 0;
        tick();

        // Initial zeroize of both instances gives a known array.
        a_zero = 1; b_zero = 1;
        tick();
        idle_in();
        na = 0; nb = 0; guard = 0;
        while ((a_busy || b_busy) && guard < 200) begin
            if (a_busy) na++;
            if (b_busy) nb++;
            tick();
            guard++;
        end
        chk("init_zero_a_len", na, 64);
        chk("init_zero_b_len", nb, 48);
        zero_models_a();
        for (int r = 0; r < 48; r++) begin mb[r] = 0; cb[r] = 0; end

        // Table-driven single-cycle vectors on the latency-1 instance.
        tbl[0] = '{1'b1, 4'hF, 6'd5,  32'hAABBCCDD, 1'b0, 6'd0,  1'b0, 32'h00000000};
        tbl[1] = '{1'b1, 4'h5, 6'd5,  32'h11223344, 1'b0, 6'd0,  1'b0, 32'h00000000};
        tbl[2] = '{1'b0, 4'h0, 6'd0,  32'h00000000, 1'b1, 6'd5,  1'b1, 32'hAA22CC44};
        tbl[3] = '{1'b0, 4'h0, 6'd0,  32'h00000000, 1'b0, 6'd0,  1'b0, 32'hAA22CC44};
        tbl[4] = '{1'b1, 4'h3, 6'd3,  32'hFFFFFFFF, 1'b1, 6'd3,  1'b1, 32'h0000FFFF};
        tbl[5] = '{1'b0, 4'h0, 6'd0,  32'h00000000, 1'b1, 6'd3,  1'b1, 32'h0000FFFF};
        tbl[6] = '{1'b1, 4'h0, 6'd5,  32'hDEADBEEF, 1'b1, 6'd5,  1'b1, 32'hAA22CC44};
        tbl[7] = '{1'b0, 4'h0, 6'd0,  32'h00000000, 1'b1, 6'd5,  1'b1, 32'hAA22CC44};
        tbl[8] = '{1'b1, 4'hF, 6'd63, 32'h12345678, 1'b1, 6'd63, 1'b1, 32'h12345678};
        tbl[9] = '{1'b0, 4'h0, 6'd0,  32'h00000000, 1'b1, 6'd6,  1'b1, 32'h00000000};
        for (int i = 0; i < 10; i++) begin
            a_we = tbl[i].we; a_strb = tbl[i].strb; a_waddr = tbl[i].waddr; a_wdata = tbl[i].wdata;
            a_re = tbl[i].re; a_raddr = tbl[i].raddr;
            if (a_we) begin
                ma[a_waddr] = mrg(ma[a_waddr], a_wdata, a_strb);
                ca[a_waddr] = ca[a_waddr] & ~a_strb;
            end
            tick();
            chk($sformatf("tbl%0d_rvalid", i), a_rvalid, tbl[i].exp_v);
            chk($sformatf("tbl%0d_rdata", i), a_rdata, tbl[i].exp_d);
`ifdef ABR_RAM_PARITY_EN
            chk($sformatf("tbl%0d_perr", i), a_perr, 0);
`endif
        end
        idle_in();

        // Latency-2 instance: out-of-range drop/read and a normal read of the last row.
        b_we = 1; b_strb = 4'hF; b_waddr = 6'd50; b_wdata = 32'hCAFEBABE;
        tick();
        b_waddr = 6'd47; b_wdata = 32'h13579BDF; mb[47] = 32'h13579BDF;
        tick();
        idle_in();
        b_re = 1; b_raddr = 6'd50;
        tick();
        chk("b_oor_vld_early", b_rvalid, 0);
        b_raddr = 6'd47;
        tick();
        chk("b_oor_vld", b_rvalid, 1);
        chk("b_oor_data", b_rdata, 0);
        b_re = 0;
        tick();
        chk("b_47_vld", b_rvalid, 1);
        chk("b_47_data", b_rdata, 32'h13579BDF);
        tick();
        chk("b_hold_vld", b_rvalid, 0);
        chk("b_hold_data", b_rdata, 32'h13579BDF);
        b_re = 1; b_raddr = 6'd2;
        tick();
        b_re = 0;
        chk("b_2_vld_early", b_rvalid, 0);
        tick();
        chk("b_2_vld", b_rvalid, 1);
        chk("b_2_data", b_rdata, 0);
        idle_in();

        // Full zeroize with write/read traffic that must be ignored.
        fill_a();
        a_re = 1; a_raddr = 6'd10;
        tick();
        chk("pre_zero_rdata", a_rdata, ma[10]);
        a_re = 0; a_zero = 1;
        tick();
        a_zero = 0;
        chk("zero_start_busy", a_busy, 1);
        chk("zero_start_rdata", a_rdata, 0);
        na = 0;
        while (a_busy && na < 200) begin
            a_we = 1; a_strb = 4'hF; a_waddr = 6'($urandom_range(0, 63)); a_wdata = $urandom | 32'h1;
            a_re = 1; a_raddr = 6'($urandom_range(0, 63)); a_zero = 1'($urandom_range(0, 1));
            tick();
            na++;
            chk("zero_rvalid", a_rvalid, 0);
        end
        idle_in();
        chk("zero_busy_len", na, 64);
        zero_models_a();
        for (int r = 0; r < 64; r++) begin
            a_re = 1; a_raddr = 6'(r);
            tick();
            chk($sformatf("zeroed_row%0d", r), a_rdata, 0);
        end
        idle_in();
        tick();

        // Reset while zeroize is at row 10.
        fill_a();
        a_zero = 1;
        tick();
        a_zero = 0;
        repeat (10) tick();
        rst = 1;
        tick();
        chk("abort_busy", a_busy, 0);
        chk("abort_rdata", a_rdata, 0);
        chk("abort_rvalid", a_rvalid, 0);
        rst = 0;
        for (int r = 0; r < 10; r++) begin ma[r] = 0; ca[r] = 0; end
        tick();
        chk("abort_busy_stays", a_busy, 0);
        for (int r = 0; r < 64; r++) begin
            a_re = 1; a_raddr = 6'(r);
            tick();
            chk($sformatf("abort_row%0d", r), a_rdata, ma[r]);
        end
        idle_in();

`ifdef ABR_RAM_PARITY_EN
        a_we = 1; a_strb = 4'hF; a_waddr = 6'd7; a_wdata = 32'h01020304; a_inj = 4'b0100;
        ma[7] = 32'h01020304; ca[7] = 4'b0100;
        tick();
        idle_in();
        a_re = 1; a_raddr = 6'd7;
        tick();
        a_re = 0;
        chk("par_vld", a_rvalid, 1);
        chk("par_perr", a_perr, 4'b0100);
        tick();
        chk("par_perr_idle", a_perr, 0);
        a_zero = 1;
        tick();
        a_zero = 0;
        guard = 0;
        while (a_busy && guard < 200) begin tick(); guard++; end
        chk("par_zero_len", guard, 64);
        zero_models_a();
        a_re = 1; a_raddr = 6'd7;
        tick();
        a_re = 0;
        chk("par_after_zero_perr", a_perr, 0);
        chk("par_after_zero_data", a_rdata, 0);
        idle_in();
`endif

        // Randomized traffic on both instances against the array models.
        rst = 1;
        tick();
        rst = 0;
        last_a = 0; last_b = 0; pb_v = 0; pb_d = 0; pb_p = 0;
        for (int i = 0; i < 600; i++) begin
            a_we = 1'($urandom_range(0, 1)); a_strb = 4'($urandom); a_waddr = 6'($urandom_range(0, 7));
            a_wdata = $urandom; a_re = 1'($urandom_range(0, 1)); a_raddr = 6'($urandom_range(0, 7));
            b_we = 1'($urandom_range(0, 1)); b_strb = 4'($urandom); b_waddr = 6'($urandom_range(44, 52));
            b_wdata = $urandom; b_re = 1'($urandom_range(0, 1)); b_raddr = 6'($urandom_range(44, 52));
`ifdef ABR_RAM_PARITY_EN
            a_inj = 4'($urandom); b_inj = 4'($urandom);
`endif
            ea_v = a_re; ea_d = last_a; ea_p = 0;
            if (a_re) begin
                ea_d = ma[a_raddr]; ea_p = ca[a_raddr];
                if (a_we && a_waddr == a_raddr) begin
                    ea_d = mrg(ea_d, a_wdata, a_strb);
                    ea_p = (ea_p & ~a_strb) | (a_inj & a_strb);
                end
            end
            if (a_we) begin
                ma[a_waddr] = mrg(ma[a_waddr], a_wdata, a_strb);
                ca[a_waddr] = (ca[a_waddr] & ~a_strb) | (a_inj & a_strb);
            end
            eb_v = b_re; eb_d = 0; eb_p = 0;
            if (b_re && b_raddr < 48) begin
                eb_d = mb[b_raddr]; eb_p = cb[b_raddr];
                if (b_we && b_waddr == b_raddr) begin
                    eb_d = mrg(eb_d, b_wdata, b_strb);
                    eb_p = (eb_p & ~b_strb) | (b_inj & b_strb);
                end
            end
            if (b_we && b_waddr < 48) begin
                mb[b_waddr] = mrg(mb[b_waddr], b_wdata, b_strb);
                cb[b_waddr] = (cb[b_waddr] & ~b_strb) | (b_inj & b_strb);
            end
            tick();
            chk("rnd_a_vld", a_rvalid, ea_v);
            chk("rnd_a_data", a_rdata, ea_d);
            last_a = ea_d;
            chk("rnd_b_vld", b_rvalid, pb_v);
            chk("rnd_b_data", b_rdata, pb_v ? pb_d : last_b);
            if (pb_v) last_b = pb_d;
`ifdef ABR_RAM_PARITY_EN
            chk("rnd_a_perr", a_perr, ea_p);
            chk("rnd_b_perr", b_perr, pb_v ? pb_p : 4'h0);
`endif
            pb_v = eb_v; pb_d = eb_d; pb_p = eb_p;
        end
        idle_in();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/abr_1r1w_be_zram.md
Name: abr_1r1w_be_zram

Overview:
Parametrised one-read/one-write RAM with per-lane write strobes. Over the plain byte-enable RAM it adds:
- a configurable read pipeline (1 or 2 cycles) with a valid flag;
- write-first forwarding on same-address collisions;
- out-of-range address protection;
- a hardware zeroize sequencer that clears every row.

It is the storage primitive for ML-DSA/ML-KEM coefficient and key buffers that must be scrubbed at end of operation.

Parameters:
- DEPTH, 64, number of rows; need not be a power of two.
- DATA_WIDTH, 32, row width in bits; must be a multiple of STROBE_WIDTH.
- STROBE_WIDTH, 8, bits per write lane; NUM_LANES = DATA_WIDTH/STROBE_WIDTH.
- READ_LATENCY, 1, cycles from re_i to rdata_o; legal values 1 or 2; elaboration error otherwise.
- ADDR_WIDTH (localparam), $clog2(DEPTH), address width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- zeroize_i  input  1  start zeroize pulse.
- busy_o  output  1  zeroize in progress.
- we_i  input  1  write enable.
- wstrobe_i  input  NUM_LANES  per-lane write enable.
- waddr_i  input  ADDR_WIDTH  write address.
- wdata_i  input  NUM_LANES x STROBE_WIDTH  write data, packed lanes.
- re_i  input  1  read enable.
- raddr_i  input  ADDR_WIDTH  read address.
- rdata_o  output  DATA_WIDTH  read data.
- rvalid_o  output  1  rdata_o updated this cycle.
- perr_inject_i  input  NUM_LANES  parity corruption on write (only with ABR_RAM_PARITY_EN).
- perr_o  output  NUM_LANES  per-lane parity error (only with ABR_RAM_PARITY_EN).

Behaviour:
- Reset (rst_i=1 at posedge):
  - FSM to IDLE; zeroize counter 0; busy_o=0.
  - rdata_o=0, rvalid_o=0, all read pipeline stages and valids cleared, perr_o=0.
  - Array contents are NOT cleared by reset.
- FSM has two states: IDLE and ZERO.
  - IDLE -> ZERO when zeroize_i=1. busy_o=1 from the next cycle.
  - In ZERO, one row per cycle at address cnt is written all-zero (parity bits correct for zero); cnt increments.
  - ZERO -> IDLE at the cycle after the write of row DEPTH-1. Zeroize occupies exactly DEPTH cycles with busy_o=1.
  - zeroize_i while in ZERO is ignored; there is no restart.
  - During ZERO, we_i and re_i are ignored. No new reads issue, so rvalid_o stays 0 after in-flight reads drain. rdata_o is forced to 0 on the first ZERO cycle.
  - Reset mid-zeroize aborts to IDLE. The array is left partially cleared; software must re-issue the zeroize.
- Write (IDLE, we_i=1, waddr_i<DEPTH): lane i of row waddr_i is updated iff wstrobe_i[i]; other lanes are retained. we_i with all strobes 0 is a no-op.
- Read (IDLE, re_i=1):
  - rdata_o and rvalid_o update READ_LATENCY cycles after re_i.
  - rvalid_o is a one-cycle pulse per read; back-to-back reads give full throughput.
  - rdata_o holds its last value when no read completes.
- Collision (re_i & we_i, raddr_i==waddr_i, both in range): returned row = wdata lanes where wstrobe_i=1, old lanes elsewhere (write-first merge).
- Out of range (address >= DEPTH):
  - Writes are dropped.
  - Reads return 0 with rvalid_o asserted normally.
- READ_LATENCY=2 adds one output register after the array read. Pipeline data and valid are flushed to 0 by reset only.

Optional Feature:
- Macro: ABR_RAM_PARITY_EN.
- Defined:
  - Each lane stores an extra even-parity bit computed on write; stored parity = computed ^ perr_inject_i[i].
  - On read, perr_o[i] = stored parity ^ recomputed parity of the returned lane, aligned with rvalid_o; 0 when rvalid_o=0.
  - Forwarded lanes use the incoming write parity, including injection.
  - Zeroize writes correct parity.
- Undefined: perr_inject_i and perr_o ports are absent, and no parity storage is generated.

Test Plan:
- Write 0xAABBCCDD to row 5 with strobe 4'hF, then write 0x11223344 to row 5 with strobe 4'b0101. Read row 5 (READ_LATENCY=1) -> rdata_o=0xAA22CC44 one cycle after re_i, rvalid_o pulse of 1 cycle.
- Collision: row 3 holds 0x0; same cycle we_i to row 3 with 0xFFFFFFFF, strobe 4'b0011, and re_i at row 3 -> rdata_o=0x0000FFFF. Re-read next cycle -> 0x0000FFFF.
- Zeroize: fill all 64 rows, pulse zeroize_i -> busy_o high exactly 64 cycles, we_i/re_i ignored during it. Afterwards every row reads 0.
- Reset mid-zeroize at cycle 10 -> busy_o=0, rdata_o=0, rvalid_o=0 next cycle. Rows 0-9 read 0; rows 10-63 keep their old data.
- DEPTH=48, READ_LATENCY=2: write to address 50 is dropped and a read of 50 returns 0. A read of row 47 returns correct data 2 cycles after re_i.
- ABR_RAM_PARITY_EN: write row 7 with perr_inject_i=4'b0100 -> reading row 7 gives perr_o=4'b0100 with rvalid_o. After zeroize, the read gives perr_o=0.
